// File: rtl/mul_pkg.sv
// Shared types for the pipelined multiplier: operand mode, per-stage control
// and the accept-to-output latency helper.
package mul_pkg;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_mode_e;

  typedef struct packed {
    logic valid;
    logic neg;
  } stage_ctl_t;

  function automatic int mul_lat(input int width);
    return $clog2(width) + 2;
  endfunction

endpackage

// File: rtl/mul_add_pipe_if.sv
// Operand and product handshakes of mul_add_pipe, with the tag sideband.
interface mul_add_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_signed;
  logic [TAG_W-1:0]   tag_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] mul_out;
  logic [TAG_W-1:0]   tag_out;

  modport master (
    output in_valid, mul_a, mul_b, mul_signed, tag_in, out_ready,
    input  in_ready, out_valid, mul_out, tag_out
  );

  modport slave (
    input  in_valid, mul_a, mul_b, mul_signed, tag_in, out_ready,
    output in_ready, out_valid, mul_out, tag_out
  );
endinterface

// File: rtl/mul_tree_level.sv
// One registered level of the partial-product adder tree: N_IN operands are
// summed pairwise into N_IN/2 results; control/tag bits ride along.
module mul_tree_level #(
  parameter int N_IN   = 2,
  parameter int SUM_W  = 16,
  parameter int META_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  input  logic [N_IN*SUM_W-1:0]       i_data,
  input  logic [META_W-1:0]           i_meta,
  output logic [(N_IN/2)*SUM_W-1:0]   o_data,
  output logic [META_W-1:0]           o_meta
);
  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*SUM_W-1:0] w_sum;
  logic [N_OUT*SUM_W-1:0] r_data;
  logic [META_W-1:0]      r_meta;

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_sum[j*SUM_W +: SUM_W] = i_data[(2*j)*SUM_W +: SUM_W] + i_data[(2*j+1)*SUM_W +: SUM_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
    end else if (i_en) begin
      r_meta <= i_meta;
    end
  end

  // NOTE: datapath flops are not reset; the valid bit alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_data <= w_sum;
    end
  end

  assign o_data = r_data;
  assign o_meta = r_meta;
endmodule

// File: rtl/mul_add_pipe.sv
// Pipelined shift-and-add multiplier: operand conditioning, registered adder
// tree, output negate, and a global stall driven by the output handshake.
module mul_add_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst,
  mul_add_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int PW     = 2 * WIDTH;

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [TAG_W-1:0] tag;
  } stage_t;

  localparam int META_W = $bits(stage_t);

  logic                        w_stall;
  logic                        w_en;
  logic                        w_is_signed;
  logic                        w_neg;
  logic [WIDTH-1:0]            w_mag_a;
  logic [WIDTH-1:0]            w_mag_b;
  stage_t                      r_s1;
  logic [WIDTH-1:0]            r_mag_a;
  logic [WIDTH-1:0]            r_mag_b;
  logic [WIDTH*PW-1:0]         w_pp;
  wire  [(2*WIDTH-1)*PW-1:0]   w_tree;
  wire  [(LEVELS+1)*META_W-1:0] w_meta;
  stage_t                      w_last;
  logic [PW-1:0]               w_sum;
  logic                        r_out_valid;
  logic [TAG_W-1:0]            r_out_tag;
  logic [PW-1:0]               r_mul_out;

  // A held product freezes every stage, so nothing behind it can be lost or reordered.
  assign w_stall      = r_out_valid && !bus.out_ready;
  assign w_en         = !w_stall;
  assign bus.in_ready = !w_stall && !rst;

  // Signed operands become magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value.
  always_comb begin
    w_is_signed = (mul_mode_e'(bus.mul_signed) == MUL_SIGNED);
    w_mag_a     = (w_is_signed && bus.mul_a[WIDTH-1]) ? -bus.mul_a : bus.mul_a;
    w_mag_b     = (w_is_signed && bus.mul_b[WIDTH-1]) ? -bus.mul_b : bus.mul_b;
    w_neg       = w_is_signed && (bus.mul_a[WIDTH-1] ^ bus.mul_b[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (w_en) begin
      r_s1.ctl.valid <= bus.in_valid && bus.in_ready;
      r_s1.ctl.neg   <= w_neg;
      r_s1.tag       <= bus.tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
    end
  end

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pp[i*PW +: PW] = r_mag_b[i] ? (PW'(r_mag_a) << i) : '0;
    end
  end

  // w_tree packs every level's operands end to end: level l reads WIDTH>>l sums, writes half as many.
  assign w_tree[WIDTH*PW-1:0] = w_pp;
  assign w_meta[META_W-1:0]   = r_s1;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN    = WIDTH >> l;
    localparam int IN_OFF  = (2*WIDTH - 2*N_IN) * PW;
    localparam int OUT_OFF = (2*WIDTH - N_IN) * PW;

    mul_tree_level #(
      .N_IN  (N_IN),
      .SUM_W (PW),
      .META_W(META_W)
    ) u_level (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en),
      .i_data(w_tree[IN_OFF +: N_IN*PW]),
      .i_meta(w_meta[l*META_W +: META_W]),
      .o_data(w_tree[OUT_OFF +: (N_IN/2)*PW]),
      .o_meta(w_meta[(l+1)*META_W +: META_W])
    );
  end

  assign w_sum  = w_tree[(2*WIDTH-2)*PW +: PW];
  assign w_last = w_meta[LEVELS*META_W +: META_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_mul_out   <= '0;
    end else if (w_en) begin
      r_out_valid <= w_last.ctl.valid;
      r_out_tag   <= w_last.tag;
      r_mul_out   <= w_last.ctl.neg ? -w_sum : w_sum;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.tag_out   = r_out_tag;
  assign bus.mul_out   = r_mul_out;
endmodule

// File: tb/tb_mul_add_pipe.sv
// Directed bench for mul_add_pipe: a WIDTH=4 latency probe plus a WIDTH=8
// instance driven through corner products, a random stream, stall and reset.
module tb_mul_add_pipe;
  localparam int LAT4 = 4;
  localparam int LAT8 = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul_add_pipe_if #(.WIDTH(4), .TAG_W(4)) if4 ();
  mul_add_pipe_if #(.WIDTH(8), .TAG_W(4)) if8 ();

  mul_add_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  mul_add_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  va [32];
  logic [7:0]  vb [32];
  logic        vs [32];
  logic [3:0]  vt [32];
  logic [15:0] ve [32];
  int          n_vec;
  int          sent;
  int          got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain integer multiply after sign/zero extension.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    byte sa_b;
    byte sb_b;
    int  sa;
    int  sb;
    sa_b = a;
    sb_b = b;
    sa   = s ? int'(sa_b) : int'(a);
    sb   = s ? int'(sb_b) : int'(b);
    return 16'(sa * sb);
  endfunction

  task automatic clear_vecs();
    n_vec = 0;
    sent  = 0;
    got   = 0;
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [3:0] t, input logic [15:0] e);
    va[n_vec] = a;
    vb[n_vec] = b;
    vs[n_vec] = s;
    vt[n_vec] = t;
    ve[n_vec] = e;
    n_vec++;
  endtask

  task automatic drive8(input int idx);
    if8.mul_a      = va[idx];
    if8.mul_b      = vb[idx];
    if8.mul_signed = vs[idx];
    if8.tag_in     = vt[idx];
    if8.in_valid   = 1'b1;
  endtask

  // Offers the queued vectors back to back and checks every product in order;
  // gaps counts idle output cycles once the first product has appeared.
  task automatic run_stream(input string name, output int gaps);
    bit started;
    int cyc;
    started = 1'b0;
    cyc     = 0;
    gaps    = 0;
    while (got < n_vec && cyc < 200) begin
      if (sent < n_vec) drive8(sent);
      else if8.in_valid = 1'b0;
      @(negedge clk);
      if (if8.in_valid && if8.in_ready) sent++;
      if (if8.out_valid && if8.out_ready) begin
        check($sformatf("%s_prod%0d", name, got), 32'(if8.mul_out), 32'(ve[got]));
        check($sformatf("%s_tag%0d", name, got), 32'(if8.tag_out), 32'(vt[got]));
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if8.in_valid = 1'b0;
    check({name, "_count"}, 32'(got), 32'(n_vec));
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check(name, 32'(if8.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          gaps;
    int          bad;
    int          seen;
    logic [7:0]  p4;
    logic [3:0]  t4;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [3:0]  rt;

    rst = 1'b1;
    if4.in_valid = 1'b0; if4.mul_a = '0; if4.mul_b = '0; if4.mul_signed = 1'b0;
    if4.tag_in = '0; if4.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.mul_a = '0; if8.mul_b = '0; if8.mul_signed = 1'b0;
    if8.tag_in = '0; if8.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    check("rst_mul_out8", 32'(if8.mul_out), 32'd0);
    check("rst_tag_out8", 32'(if8.tag_out), 32'd0);
    check("rst_in_ready8", 32'(if8.in_ready), 32'd0);
    check("rst_in_ready4", 32'(if4.in_ready), 32'd0);
    check("rst_out_valid4", 32'(if4.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready8", 32'(if8.in_ready), 32'd1);
    check("rel_in_ready4", 32'(if4.in_ready), 32'd1);

    // WIDTH=4 latency: 15*15 unsigned, counting the accept cycle as cycle 1.
    @(posedge clk);
    #1;
    if4.mul_a = 4'hF; if4.mul_b = 4'hF; if4.mul_signed = 1'b0; if4.tag_in = 4'd3;
    if4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    lat = 0;
    p4  = '0;
    t4  = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (if4.out_valid) begin
        lat = c;
        p4  = if4.mul_out;
        t4  = if4.tag_out;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("w4_latency", 32'(lat), 32'(LAT4));
    check("w4_prod", 32'(p4), 32'hE1);
    check("w4_tag", 32'(t4), 32'd3);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w4_no_dup", 32'(if4.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // WIDTH=8 corner products, back to back with mixed modes.
    clear_vecs();
    add_vec(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
    add_vec(8'hFD, 8'h05, 1'b1, 4'h2, 16'hFFF1);
    add_vec(8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080);
    add_vec(8'hFF, 8'hFF, 1'b0, 4'h4, 16'hFE01);
    add_vec(8'h00, 8'hF9, 1'b1, 4'h5, 16'h0000);
    add_vec(8'h00, 8'h00, 1'b0, 4'h6, 16'h0000);
    add_vec(8'h7F, 8'h7F, 1'b1, 4'h7, 16'h3F01);
    add_vec(8'h80, 8'h02, 1'b0, 4'h8, 16'h0100);
    add_vec(8'h07, 8'hFF, 1'b1, 4'h9, 16'hFFF9);
    add_vec(8'hFF, 8'h01, 1'b0, 4'hA, 16'h00FF);
    run_stream("dir", gaps);
    check("dir_gaps", 32'(gaps), 32'd0);
    expect_idle("dir_no_dup");

    // 20 random mixed-mode transactions, out_ready held high.
    clear_vecs();
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      rt = 4'($urandom_range(0, 15));
      add_vec(ra, rb, rs, rt, ref_mul(ra, rb, rs));
    end
    run_stream("rnd", gaps);
    check("rnd_gaps", 32'(gaps), 32'd0);
    expect_idle("rnd_no_dup");

    // Stall: fill the pipe with out_ready low, hold 6 cycles, then drain.
    clear_vecs();
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'(i % 2);
      rt = 4'(i + 3);
      add_vec(ra, rb, rs, rt, ref_mul(ra, rb, rs));
    end
    if8.out_ready = 1'b0;
    for (int c = 0; c < 20 && sent < LAT8; c++) begin
      drive8(sent);
      @(negedge clk);
      if (if8.in_valid && if8.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    check("stall_fill", 32'(sent), 32'(LAT8));
    drive8(sent);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if8.in_ready !== 1'b0 || if8.out_valid !== 1'b1 ||
          if8.mul_out !== ve[0] || if8.tag_out !== vt[0]) bad++;
      @(posedge clk);
      #1;
    end
    check("stall_hold", 32'(bad), 32'd0);
    if8.out_ready = 1'b1;
    run_stream("stall", gaps);
    check("stall_gaps", 32'(gaps), 32'd0);
    expect_idle("stall_no_dup");

    // Reset with three transactions in flight.
    clear_vecs();
    add_vec(8'h12, 8'h34, 1'b0, 4'hB, 16'h03A8);
    add_vec(8'hF0, 8'h10, 1'b1, 4'hC, 16'hFF00);
    add_vec(8'h55, 8'h03, 1'b0, 4'hD, 16'h00FF);
    for (int c = 0; c < 10 && sent < 3; c++) begin
      drive8(sent);
      @(negedge clk);
      if (if8.in_valid && if8.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    check("rst_mid_sent", 32'(sent), 32'd3);
    if8.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 32'(if8.out_valid), 32'd0);
    check("rst_mid_mul_out", 32'(if8.mul_out), 32'd0);
    check("rst_mid_in_ready", 32'(if8.in_ready), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if8.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("rst_mid_discard", 32'(seen), 32'd0);

    clear_vecs();
    add_vec(8'hFE, 8'hFE, 1'b1, 4'hE, 16'h0004);
    run_stream("post_rst", gaps);
    expect_idle("post_rst_no_dup");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mul_add_pipe.md
# mul_add_pipe

Parametrised, pipelined shift-and-add multiplier: WIDTH×WIDTH operands, 2·WIDTH-bit product, with per-transaction signed/unsigned mode. Partial products are reduced by a registered binary adder tree, one tree level per stage. Valid/ready handshakes on both sides carry a tag sideband. It is the streaming replacement for the fixed 4-bit combinational multiply tree and sits between operand producers and accumulate/datapath consumers.

## Interface
- WIDTH, 8: operand width; power of two, 2..32
- TAG_W, 4: width of opaque sideband carried with each product
- LAT (localparam), $clog2(WIDTH)+2: accept-to-output latency in cycles
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block can accept this cycle
- mul_a  in  WIDTH  multiplicand
- mul_b  in  WIDTH  multiplier
- mul_signed  in  1  1 = two's-complement operands and product, 0 = unsigned
- tag_in  in  TAG_W  sideband, returned unmodified with the product
- out_valid  out  1  product present
- out_ready  in  1  consumer accepts this cycle
- mul_out  out  2·WIDTH  product
- tag_out  out  TAG_W  tag of the product on mul_out

## Operation
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready; in_ready = !stall && !rst. While stalled, every stage register holds. No bubble collapsing.
- Stage 1, conditioning: in signed mode, operands replaced by magnitudes (|−2^(WIDTH−1)| = 2^(WIDTH−1), held exactly as WIDTH-bit unsigned); neg flag = sign(a) XOR sign(b); unsigned mode: neg = 0, operands pass unchanged.
- Stages 2..LAT−1, tree: level 1 forms WIDTH partial products pp_i = mag_b[i] ? mag_a << i : 0 (2·WIDTH bits, zero-extended) and adds adjacent pairs; each further level adds pairs; after $clog2(WIDTH) levels a single 2·WIDTH-bit sum remains. All additions are 2·WIDTH bits wide; no overflow is possible.
- Stage LAT, output: mul_out = neg ? −sum : sum (2·WIDTH-bit two's complement); 0 × negative yields 0, never −0 artefacts.
- valid, neg and tag travel with data through every stage.
- mode is per transaction; mixed signed/unsigned streams are legal back to back.

## Timing
- Reset: all stage valids 0, out_valid 0, mul_out 0, tag_out 0; in_ready 0 while rst high, 1 the cycle after release.
- Latency: transaction accepted at edge k appears with out_valid = 1 after edge k+LAT−1 (visible in cycle k+LAT−1..) when no stall; WIDTH=8 → LAT=5, WIDTH=4 → LAT=4.
- Throughput: one transaction per cycle while out_ready stays high.
- Stall: out_ready low with out_valid high freezes mul_out/tag_out/out_valid and all stages; in_ready low in the same cycle (combinational from out_ready).
- out_valid low: pipeline advances regardless of out_ready; bubbles propagate.
- Reset mid-operation: all in-flight transactions discarded, no product emitted after reset.
- Simultaneous deliver and accept in one cycle: legal, both occur.

## Structure
- Package mul_pkg: mul_mode_e (MUL_UNSIGNED, MUL_SIGNED), helper function for LAT, stage struct {valid, neg, tag}.
- Sub-module mul_tree_level: one registered pairwise-add level (parameters N_IN, SUM_W, with enable), instantiated $clog2(WIDTH) times via generate.
- Top holds conditioning stage, output negate stage, and stall/ready logic.

## Test plan
- WIDTH=4, unsigned 15×15, tag 3 -> mul_out 225 (8'hE1), tag_out 3, out_valid exactly LAT=4 cycles after accept.
- WIDTH=8, signed −128×−128 -> 16'h4000; signed −3×5 -> 16'hFFF1; signed −128×127 -> 16'hC080; unsigned 255×255 -> 16'hFE01.
- WIDTH=8, 20 back-to-back random mixed-mode transactions, out_ready=1 -> 20 consecutive out_valid cycles, in order, all matching reference model and tags.
- Hold out_ready=0 for 6 cycles with pipeline full -> mul_out/tag_out stable, in_ready=0, no loss/duplication after release.
- Assert rst for one cycle with 3 transactions in flight -> out_valid=0, mul_out=0 following edge; none of the 3 ever emitted; next accept behaves normally.
- Zero operands: signed 0×−7 -> 0; unsigned 0×0 -> 0.
